// File: rtl/alu_seq_pkg.sv
// Shared types and default widths for the ALU op sequencer and the result
// multiplexer instantiated beside it.
package alu_seq_pkg;

  localparam int unsigned SEQ_SIZE = 8;
  localparam int unsigned SEQ_N    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    OUT  = 2'b10
  } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, multiplexer and result handshake signals of the ALU op sequencer.
// The sequencer takes the slave side; the surrounding logic takes the master side.
interface alu_op_sequencer_if
  import alu_seq_pkg::*;
#(
  parameter int unsigned SIZE = SEQ_SIZE,
  parameter int unsigned N    = SEQ_N
);

  logic            cmd_valid;
  logic            cmd_ready;
  logic [N-1:0]    cmd_op;
  logic [N-1:0]    mux_select;
  logic [SIZE-1:0] mux_out;
  logic            res_valid;
  logic            res_ready;
  logic [SIZE-1:0] res_data;
  logic [N-1:0]    res_op;
  logic            busy;

  modport slave (
    input  cmd_valid, cmd_op, mux_out, res_ready,
    output cmd_ready, mux_select, res_valid, res_data, res_op, busy
  );

  modport master (
    output cmd_valid, cmd_op, mux_out, res_ready,
    input  cmd_ready, mux_select, res_valid, res_data, res_op, busy
  );

endinterface

// File: rtl/alu_op_sequencer_settle_timer.sv
// Loadable down-counter that counts the settle cycles between a select change
// and the capture of the multiplexer output. It stops at zero and never wraps.
module settle_timer #(
  parameter  int unsigned SETTLE = 1,
  localparam int unsigned CW     = $clog2(SETTLE + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(SETTLE - 1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Control stage around the ALU result multiplexer: accepts one op, drives the
// select, waits SETTLE cycles, captures the mux output and hands it downstream.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned SIZE   = SEQ_SIZE,
  parameter int unsigned N      = SEQ_N,
  parameter int unsigned SETTLE = 1
) (
  input logic               clk,
  input logic               rst_n,
  alu_op_sequencer_if.slave bus
);

  if (SETTLE < 1) begin : g_bad_settle
    $error("alu_op_sequencer: SETTLE must be at least 1");
  end

  seq_state_e      state_q, state_d;
  logic [N-1:0]    sel_q;
  logic [N-1:0]    op_q;
  logic [SIZE-1:0] data_q;
  logic            load;
  logic            capture;
  logic            timer_zero;

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .dec_i  (state_q == WAIT),
    .zero_o (timer_zero)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          load    = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (timer_zero) begin
          capture = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, so outputs read as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      op_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        sel_q <= bus.cmd_op;
        op_q  <= bus.cmd_op;
      end
      // mux_out is only trusted on the capture edge, after the select has settled
      if (capture) begin
        data_q <= bus.mux_out;
      end
    end
  end

  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.res_valid  = (state_q == OUT);
  assign bus.mux_select = sel_q;
  assign bus.res_data   = data_q;
  assign bus.res_op     = op_q;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Control stage wrapped around the ALU result multiplexer. It accepts one operation request at a time over a valid/ready handshake and drives the multiplexer's select input. It waits a fixed number of settle cycles for the selected ALU result to propagate, then registers the multiplexer output. The captured result is presented downstream on a second valid/ready handshake.

## Interface
Parameters:
- SIZE, 8, bits per ALU result; equals the multiplexer data width.
- N, 3, select width; the multiplexer chooses among 2**N results.
- SETTLE, 1, cycles from select change to capture; must be ≥1; SETTLE=0 fails elaboration.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- cmd_valid  in  1  request present.
- cmd_ready  out  1  block can accept a request; equals (state==IDLE).
- cmd_op  in  N  index of the ALU result to select.
- mux_select  out  N  registered select, driven to the multiplexer.
- mux_out  in  SIZE  selected result returned from the multiplexer.
- res_valid  out  1  captured result available.
- res_ready  in  1  downstream accepts the result.
- res_data  out  SIZE  captured result, registered.
- res_op  out  N  op index that produced res_data.
- busy  out  1  state != IDLE.

## Operation
States:
- IDLE
  - cmd_ready=1.
  - On cmd_valid: load mux_select←cmd_op and res_op←cmd_op, load counter←SETTLE-1, then go to WAIT.
- WAIT
  - cmd_ready=0. mux_select is held.
  - If counter==0: res_data←mux_out, then go to OUT. Otherwise decrement the counter.
- OUT
  - res_valid=1.
  - res_data and res_op are held while res_ready=0.
  - On res_ready: go to IDLE.

Rules:
- All N-bit cmd_op values are legal. No range check is needed, because the multiplexer has exactly 2**N inputs.
- mux_select changes only on the accepting edge. It is stable from that edge through the capture edge and keeps its last value in IDLE.
- mux_out is sampled only on the capture edge. Values on mux_out in any other cycle are ignored.
- cmd_valid while not in IDLE is not accepted. The upstream must hold its request.
- The counter is $clog2(SETTLE+1) bits wide and has no wrap-around path.
- Reset values (asynchronous, while rst_n=0):
  - state=IDLE, so cmd_ready=1 and busy=0.
  - res_valid=0.
  - mux_select=0, res_op=0, res_data=0, counter=0.
- Reset during WAIT or OUT abandons the operation. res_valid drops immediately, and no result is produced for the abandoned request.

## Timing
- The accepting edge is the first rising edge with cmd_valid and cmd_ready both high. Call it edge A.
- mux_select shows the new op after edge A.
- The capture edge is A+SETTLE. res_valid and res_data are visible after it, so latency is SETTLE cycles.
- The result transfers on the first edge with res_valid and res_ready both high. The state is IDLE after that edge.
- Minimum request-to-request period is SETTLE+2 cycles: accept, SETTLE cycles in WAIT, one cycle in OUT, one cycle in IDLE.
- No combinational path from any input to any output, except through the state register.

## Structure
- Shared package alu_seq_pkg holds:
  - the state encoding as a 2-bit typedef: IDLE=2'b00, WAIT=2'b01, OUT=2'b10;
  - default SIZE and N constants, shared with the multiplexer instantiation.
- One natural sub-module: settle_timer, a loadable down-counter with a zero flag, parameterised by SETTLE.
- The multiplexer is instantiated beside this block in the parent, not inside it.

## Test plan
All scenarios use SIZE=8, N=3, SETTLE=2. The bench model returns mux_out = {i,i} in hex for select i (e.g. select 5 gives 0x55).

1. Reset: hold rst_n=0 with random inputs. Required: cmd_ready=1, busy=0, res_valid=0, res_data=0x00, res_op=0, mux_select=0.
2. Single op: send cmd_op=5 with res_ready=1. Required: mux_select=5 after edge A; res_valid rises after edge A+2 with res_data=0x55 and res_op=5; IDLE after edge A+3.
3. Backpressure: hold res_ready=0 for 4 cycles in OUT while the bench forces mux_out=0x00. Required: res_data stays 0x55, cmd_ready stays 0, and a pending cmd_valid is not accepted.
4. Back-to-back: send ops 1, 2, 7 with cmd_valid and res_ready held at 1. Required: accepting edges are 4 cycles apart; results are 0x11, 0x22, 0x77 in order.
5. Late mux_out change: change mux_out from 0x33 to 0x3C one cycle before the capture edge. Required: res_data=0x3C.
6. Reset mid-operation: pulse rst_n low during WAIT. Required: outputs return to reset values at once, and no res_valid appears after release until a new request is sent.
